// File: rtl/pll_reset_sequencer_if.sv
// PLL supervision bundle: PLL lock input, PLL reset and the downstream
// reset/status outputs of pll_reset_sequencer. The sequencer uses the master
// side; whatever consumes the status (top level or bench) uses the slave side.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;

  modport master (
    input  pll_locked,
    output pll_rst, sys_rst_n, ready, fail, retry_count, lock_loss_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst, sys_rst_n, ready, fail, retry_count, lock_loss_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: supervises an ECP5 EHXPLLL from the 25 MHz input-clock
// side. It pulses PLL RST, waits for a synchronized LOCK to stay high for
// STABLE_CYCLES, then releases an active-low system reset. Lock timeouts
// retry up to MAX_RETRIES times before parking in FAIL; lock loss in RUN is
// counted (saturating) and restarts the sequence.
// Optional build macro PLL_RESET_SEQ_DEGLITCH_EN: in RUN, lock loss is only
// recognised after 4 consecutive low cycles of the synchronized lock.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 2500000,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                         clk_25MHz,
  input  logic                         rst_n,
  pll_reset_sequencer_if.master        pll_if
);

  localparam int unsigned RST_W = $clog2(RST_CYCLES) + 1;
  localparam int unsigned STB_W = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_DONE  = STB_W'(STABLE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           r_state;
  logic             r_lock_meta;
  logic             r_lock_s;
  logic [RST_W-1:0] r_rst_cnt;
  logic [STB_W-1:0] r_stb_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic             r_ready;
  logic             r_fail;
  logic [1:0]       r_retry;
  logic [7:0]       r_loss_cnt;

  logic [STB_W-1:0] w_stb_inc;
  logic             w_stb_done;
  logic             w_timeout;
  logic             w_loss;

  // Two-flop synchronizer bringing the asynchronous PLL LOCK into clk_25MHz
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_if.pll_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  assign w_stb_inc  = r_stb_cnt + STB_W'(1);
  assign w_stb_done = (w_stb_inc == STB_DONE);
  assign w_timeout  = (r_tmo_cnt == TMO_LAST);

`ifdef PLL_RESET_SEQ_DEGLITCH_EN
  logic [2:0] r_low_cnt;

  assign w_loss = !r_lock_s && (r_low_cnt == 3'd3);

  // Length of the current run of low lock samples while in RUN
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_low_cnt <= '0;
    end else if (r_lock_s || (r_state != S_RUN) || w_loss) begin
      r_low_cnt <= '0;
    end else begin
      r_low_cnt <= r_low_cnt + 3'd1;
    end
  end
`else
  assign w_loss = !r_lock_s;
`endif

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RESET;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_retry     <= '0;
      r_loss_cnt  <= '0;
      r_rst_cnt   <= '0;
      r_stb_cnt   <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_RESET: begin
          if (r_rst_cnt == RST_LAST) begin
            r_state   <= S_WAIT_LOCK;
            r_pll_rst <= 1'b0;
            r_rst_cnt <= '0;
            r_stb_cnt <= '0;
            r_tmo_cnt <= '0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RST_W'(1);
          end
        end

        // WAIT_LOCK and STABLE share one branch: the stable counter is held at
        // 0 in WAIT_LOCK, so the same increment yields 1 on entry to STABLE and
        // covers STABLE_CYCLES == 1 directly. Completion beats timeout.
        S_WAIT_LOCK, S_STABLE: begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          if (r_lock_s && w_stb_done) begin
            r_state     <= S_RUN;
            r_sys_rst_n <= 1'b1;
            r_ready     <= 1'b1;
            r_retry     <= '0;
          end else if (w_timeout) begin
            r_pll_rst <= 1'b1;
            r_rst_cnt <= '0;
            if (r_retry < RETRY_MAX) begin
              r_retry <= r_retry + 2'd1;
              r_state <= S_RESET;
            end else begin
              r_fail  <= 1'b1;
              r_state <= S_FAIL;
            end
          end else if (r_lock_s) begin
            r_state   <= S_STABLE;
            r_stb_cnt <= w_stb_inc;
          end else begin
            r_state   <= S_WAIT_LOCK;
            r_stb_cnt <= '0;
          end
        end

        S_RUN: begin
          if (w_loss) begin
            r_state     <= S_RESET;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_rst_cnt   <= '0;
            if (r_loss_cnt != 8'hFF) begin
              r_loss_cnt <= r_loss_cnt + 8'd1;
            end
          end
        end

        S_FAIL: begin
          r_pll_rst   <= 1'b1;
          r_sys_rst_n <= 1'b0;
          r_fail      <= 1'b1;
        end

        default: begin
          r_state     <= S_RESET;
          r_pll_rst   <= 1'b1;
          r_sys_rst_n <= 1'b0;
          r_ready     <= 1'b0;
          r_rst_cnt   <= '0;
        end
      endcase
    end
  end

  assign pll_if.pll_rst         = r_pll_rst;
  assign pll_if.sys_rst_n       = r_sys_rst_n;
  assign pll_if.ready           = r_ready;
  assign pll_if.fail            = r_fail;
  assign pll_if.retry_count     = r_retry;
  assign pll_if.lock_loss_count = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus a randomized lock
// pattern, every cycle compared against a phase-level reference model.
module tb_pll_reset_sequencer;

  localparam int RST  = 4;
  localparam int STB  = 8;
  localparam int TMO  = 50;
  localparam int MAXR = 2;
`ifdef PLL_RESET_SEQ_DEGLITCH_EN
  localparam int LOSS_LEN = 4;
`else
  localparam int LOSS_LEN = 1;
`endif
  localparam logic [13:0] RESET_VAL = 14'h2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  pll_reset_sequencer_if bus();

  pll_reset_sequencer #(
    .RST_CYCLES   (RST),
    .STABLE_CYCLES(STB),
    .LOCK_TIMEOUT (TMO),
    .MAX_RETRIES  (MAXR)
  ) dut (
    .clk_25MHz(clk),
    .rst_n    (rst_n),
    .pll_if   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pulse / acquire / run / fail phases, lock seen 2 edges late
  typedef enum int {M_PULSE, M_ACQ, M_RUN, M_FAIL} mphase_t;
  mphase_t m_phase;
  int m_pulse_left, m_age, m_hi, m_lo, m_retries, m_losses;
  bit m_q[$];

  function automatic void model_reset();
    m_phase = M_PULSE;
    m_pulse_left = RST;
    m_age = 0; m_hi = 0; m_lo = 0; m_retries = 0; m_losses = 0;
    m_q.delete();
    m_q.push_back(1'b0);
    m_q.push_back(1'b0);
  endfunction

  function automatic void model_edge(bit lk);
    bit ls;
    ls = m_q.pop_front();
    m_q.push_back(lk);
    case (m_phase)
      M_PULSE: begin
        m_pulse_left--;
        if (m_pulse_left == 0) begin
          m_phase = M_ACQ; m_age = 0; m_hi = 0;
        end
      end
      M_ACQ: begin
        m_age++;
        m_hi = ls ? m_hi + 1 : 0;
        if (m_hi >= STB) begin
          m_phase = M_RUN; m_retries = 0; m_lo = 0;
        end else if (m_age >= TMO) begin
          if (m_retries < MAXR) begin
            m_retries++; m_phase = M_PULSE; m_pulse_left = RST;
          end else begin
            m_phase = M_FAIL;
          end
        end
      end
      M_RUN: begin
        m_lo = ls ? 0 : m_lo + 1;
        if (m_lo >= LOSS_LEN) begin
          if (m_losses < 255) m_losses++;
          m_phase = M_PULSE; m_pulse_left = RST; m_lo = 0;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [13:0] model_out();
    return {(m_phase == M_PULSE) || (m_phase == M_FAIL), m_phase == M_RUN,
            m_phase == M_RUN, m_phase == M_FAIL, 2'(m_retries), 8'(m_losses)};
  endfunction

  function automatic logic [13:0] dut_out();
    return {bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fail,
            bus.retry_count, bus.lock_loss_count};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit lk);
    bus.pll_locked = lk;
    @(posedge clk);
    if (rst_n) model_edge(lk);
    #1;
    chk("model", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset", 32'(dut_out()), 32'(RESET_VAL));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Force one lock drop from RUN and wait for the model to return to RUN
  task automatic lose_and_recover(output int cyc);
    bit seen_out;
    seen_out = 1'b0;
    cyc = 0;
    do begin
      step((cyc < LOSS_LEN) ? 1'b0 : 1'b1);
      cyc++;
      if (m_phase != M_RUN) seen_out = 1'b1;
    end while (!(seen_out && m_phase == M_RUN) && cyc < 100);
  endtask

  initial begin
    int n;
    int hi, lo;
    bit prev, cur, lk;
    int falls[$], rises[$], rrise[$];

    bus.pll_locked = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(dut_out()), 32'(RESET_VAL));
    @(negedge clk);
    rst_n = 1'b1;

    // Normal bring-up
    n = 0;
    do begin step(1'b0); n++; end while (bus.pll_rst === 1'b1 && n < 20);
    chk("pulse_len", n, RST);
    repeat (10) step(1'b0);
    n = 0;
    do begin step(1'b1); n++; end while (bus.ready !== 1'b1 && n < 40);
    chk("lock_to_ready", n, 2 + STB);
    chk("release_outs", {bus.sys_rst_n, bus.retry_count}, 3'b100);

    // Lock loss in RUN
    repeat (5) step(1'b1);
`ifdef PLL_RESET_SEQ_DEGLITCH_EN
    repeat (3) step(1'b0);
    repeat (6) step(1'b1);
    chk("glitch_ready", bus.ready, 1);
    chk("glitch_count", bus.lock_loss_count, 0);
`endif
    n = 0;
    do begin
      step((n < LOSS_LEN) ? 1'b0 : 1'b1);
      n++;
    end while (bus.sys_rst_n === 1'b1 && n < 20);
    chk("loss_latency", n, 2 + LOSS_LEN);
    chk("loss_count", bus.lock_loss_count, 1);
    n = 0;
    do begin step(1'b1); n++; end while (bus.pll_rst === 1'b1 && n < 20);
    chk("repulse_len", n, RST);
    n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin step(1'b1); n++; end
    chk("rerelease", bus.ready, 1);

    // Lock chatter during the stable window
    do_reset();
    repeat (RST) step(1'b0);
    n = 0;
    do begin step(1'b1); n++; end while (m_hi < 5 && n < 30);
    step(1'b0);
    n = 0;
    do begin step(1'b1); n++; end while (bus.ready !== 1'b1 && n < 40);
    chk("chatter_release", n, 2 + STB);
    chk("chatter_retry", bus.retry_count, 0);

    // Saturation of the lock-loss counter
    for (int i = 0; i < 260; i++) begin
      lose_and_recover(n);
      if (n >= 100) chk("sat_recover_bound", n, 0);
    end
    chk("saturate", bus.lock_loss_count, 255);

    // Async reset while in the stable window
    for (int i = 0; i < LOSS_LEN; i++) step(1'b0);
    n = 0;
    do begin step(1'b1); n++; end while (!(m_phase == M_ACQ && m_hi >= 3) && n < 40);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_mid_stable", 32'(dut_out()), 32'(RESET_VAL));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Never locks: retries then terminal failure
    prev = 1'b1; hi = 1; lo = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b0);
      cur = bus.pll_rst;
      if (cur != prev) begin
        if (prev) falls.push_back(hi);
        else begin rises.push_back(lo); rrise.push_back(int'(bus.retry_count)); end
        hi = 0; lo = 0;
      end
      if (cur) hi++; else lo++;
      prev = cur;
    end
    chk("fail_pulses", falls.size(), 3);
    chk("fail_gaps", rises.size(), 3);
    for (int i = 0; i < falls.size(); i++) chk("fail_pulse_len", falls[i], RST);
    for (int i = 0; i < rises.size(); i++) chk("fail_gap_len", rises[i], TMO);
    if (rrise.size() == 3) begin
      chk("retry_first", rrise[0], 1);
      chk("retry_second", rrise[1], 2);
    end
    chk("fail_outs", {bus.fail, bus.pll_rst, bus.sys_rst_n, bus.ready}, 4'b1100);

    // Randomized lock pattern with occasional resets
    do_reset();
    lk = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (($urandom % 500) == 0) do_reset();
      if (lk) begin
        if (($urandom % 40) == 0) lk = 1'b0;
      end else begin
        if (($urandom % 6) == 0) lk = 1'b1;
      end
      step(lk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
